decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, buffered decoded entries; power of two, >= 2.
REQ-003 SHALL have ports clk  input  1  sole clock, rising edge; reset  input  1  synchronous, active-high.
REQ-004 SHALL have ports in_valid  input  1  upstream instruction present; in_ready  output  1  entry can be accepted.
REQ-005 SHALL have ports in_instr  input  32  raw instruction; in_pc  input  XLEN  instruction address.
REQ-006 SHALL have port flush  input  1  discard all buffered entries.
REQ-007 SHALL have ports out_valid  output  1  head entry valid; out_ready  input  1  consumer takes head.
REQ-008 SHALL have ports out_pc  output  XLEN; opcode  output  7; rd, rs1, rs2  output  5 each; funct3  output  3; funct7  output  7.
REQ-009 SHALL have ports imm  output  XLEN  format-selected sign-extended immediate; fmt  output  3  R=0 I=1 S=2 B=3 U=4 J=5; illegal  output  1.

Function
REQ-010 SHALL decode combinationally at input, then store all fields plus in_pc in a DEPTH-entry FIFO; outputs SHALL always reflect the FIFO head.
REQ-011 SHALL push on in_valid&&in_ready and pop on out_valid&&out_ready, both at the same rising edge.
REQ-012 SHALL drive in_ready = (count < DEPTH); no pass-through when full, so a push into a full FIFO never occurs.
REQ-013 SHALL set out_valid = (count != 0); an entry accepted at edge N SHALL be visible with out_valid=1 after edge N (one-cycle latency).
REQ-014 SHALL support simultaneous push and pop at any non-full count, leaving count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 SHALL extract rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12], funct7=[31:25], opcode=[6:0].
REQ-016 SHALL map fmt: OP, OP-32 -> R; LOAD, OP-IMM, OP-IMM-32, JALR, SYSTEM, MISC-MEM -> I; STORE -> S; BRANCH -> B; LUI, AUIPC -> U; JAL -> J; any other opcode -> R.
REQ-017 SHALL form imm as I={[31:20]}, S={[31:25],[11:7]}, B={[31],[7],[30:25],[11:8],0}, U={[31:12],12'b0}, J={[31],[19:12],[20],[30:21],0}, each sign-extended from its MSB (bit 31 for U) to XLEN; R gives imm=0.
REQ-018 SHALL, on flush, set count and pointers to 0 at that edge; flush SHALL override a same-cycle push and pop, and out_valid SHALL be 0 the following cycle.
REQ-019 SHALL keep head fields stable while out_valid=1 and out_ready=0.

Reset
REQ-020 SHALL, while reset is high at an edge, clear count and pointers; out_valid=0, in_ready=0 during reset, in_ready=1 the cycle after release.
REQ-021 SHALL drive all head-field outputs (out_pc, opcode, rd, rs1, rs2, funct3, funct7, imm, fmt, illegal) to 0 after reset and whenever empty.
REQ-022 SHALL, when reset is asserted mid-stream, discard all entries, override flush, push and pop.

Configuration
REQ-023 SHALL, with macro DECODE_ILLEGAL_CHECK_EN defined, set illegal=1 when opcode[1:0]!=2'b11 or opcode is not in {LOAD, MISC-MEM, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM}, plus {OP-IMM-32, OP-32} only when XLEN=64.
REQ-024 SHALL, without DECODE_ILLEGAL_CHECK_EN, tie illegal to 0 and omit its FIFO storage; all other behaviour identical.

Verification
REQ-025 SHALL cover: push 0xFFF00093, pc 0x100 -> next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF (XLEN=32), out_pc=0x100.
REQ-026 SHALL cover: push 0xFE000EE3 -> fmt=3, imm=0xFFFFFFFC; push 0x01F081B3 -> fmt=0, rd=3, rs1=1, rs2=31, imm=0.
REQ-027 SHALL cover: DEPTH=4, out_ready=0, five back-to-back valid pushes -> in_ready=0 after 4th, 5th held; out_ready=1 -> four entries drain in order, then 5th accepted.
REQ-028 SHALL cover: 2 entries buffered, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count 0, pushed instruction lost.
REQ-029 SHALL cover: push 0x00000000 -> illegal=1 with DECODE_ILLEGAL_CHECK_EN, illegal=0 without; XLEN=64 push 0x0000003B -> illegal=0.
REQ-030 SHALL cover: reset pulse with 3 entries buffered -> out_valid=0, all head fields 0, in_ready=0 that cycle, 1 after release.

Source files
------------

// File: rtl/decode_stage.sv
// RV instruction decode stage: decodes fields and immediate at the input and buffers them in a DEPTH-entry FIFO.
// Optional illegal-opcode detection is enabled by defining DECODE_ILLEGAL_CHECK_EN.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Decode of the incoming instruction
  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.funct3 = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct7 = in_instr[31:25];
    case (in_instr[6:0])
      OPC_OP, OPC_OP_32: begin
        dec.fmt = FMT_R;
        dec.imm = '0;
      end
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      default: begin
        dec.fmt = FMT_R;
        dec.imm = '0;
      end
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    case (in_instr[6:0])
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM:
        dec.illegal = (in_instr[1:0] != 2'b11);
      OPC_OP_IMM_32, OPC_OP_32:
        dec.illegal = (XLEN != 64);
      default:
        dec.illegal = 1'b1;
    endcase
`endif
  end

  // Reset gates the handshakes combinationally so nothing is offered or accepted during it
  assign in_ready  = !reset && (count < DEPTH_C);
  assign out_valid = !reset && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: every read is masked by out_valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_pc = head.pc;
  assign opcode = head.opcode;
  assign rd     = head.rd;
  assign rs1    = head.rs1;
  assign rs2    = head.rs2;
  assign funct3 = head.funct3;
  assign funct7 = head.funct7;
  assign imm    = head.imm;
  assign fmt    = head.fmt;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal = head.illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table (XLEN=32 and XLEN=64 instances)
// plus hand-written full, flush and mid-stream reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;

  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] out_pc64, imm64;
  logic [6:0]  opcode64, funct7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  funct3_64, fmt64;

  int checks = 0;
  int errors = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  decode_stage #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc({32'h0, in_pc}), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .opcode(opcode64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64), .funct3(funct3_64),
    .funct7(funct7_64), .imm(imm64), .fmt(fmt64), .illegal(illegal64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [63:0] imm64;
    bit          ill32;
    bit          ill64;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty_fields(input string tag);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_pc"},    64'(out_pc), 64'd0);
    chk({tag, " fields"},    64'({opcode, rd, rs1, rs2, funct3, funct7, fmt, illegal}), 64'd0);
    chk({tag, " imm"},       64'(imm), 64'd0);
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h100, 7'h13, 3'd1,  5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'h104, 7'h63, 3'd3,  5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0};
    vecs[2]  = '{32'h01F081B3, 32'h108, 7'h33, 3'd0,  5'd3,  5'd1,  5'd31, 3'd0, 7'h00, 32'h0,        64'h0,                 1'b0, 1'b0};
    vecs[3]  = '{32'h00000000, 32'h10C, 7'h00, 3'd0,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0,        64'h0,                 1'b1, 1'b1};
    vecs[4]  = '{32'h00112623, 32'h110, 7'h23, 3'd2,  5'd12, 5'd2,  5'd1,  3'd2, 7'h00, 32'h0000000C, 64'hC,                 1'b0, 1'b0};
    vecs[5]  = '{32'h800002B7, 32'h114, 7'h37, 3'd4,  5'd5,  5'd0,  5'd0,  3'd0, 7'h40, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFDFF0EF, 32'h118, 7'h6F, 3'd5,  5'd1,  5'd31, 5'd29, 3'd7, 7'h7F, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000007F, 32'h11C, 7'h7F, 3'd0,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0,        64'h0,                 1'b1, 1'b1};
    vecs[8]  = '{32'h0000003B, 32'h120, 7'h3B, 3'd0,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0,        64'h0,                 1'b1, 1'b0};
    vecs[9]  = '{32'h00008067, 32'h124, 7'h67, 3'd1,  5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h0,        64'h0,                 1'b0, 1'b0};
    vecs[10] = '{32'h00000010, 32'h128, 7'h10, 3'd0,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0,        64'h0,                 1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    tick();
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk_empty_fields("reset");
    tick();
    reset = 1'b0;
    tick();
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);

    // Decode table: push one, inspect head, pop it
    for (int i = 0; i < 11; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      push_one(vecs[i].instr, vecs[i].pc);
      chk({t, " out_valid"}, 64'(out_valid), 64'd1);
      chk({t, " out_pc"},    64'(out_pc), 64'(vecs[i].pc));
      chk({t, " opcode"},    64'(opcode), 64'(vecs[i].opc));
      chk({t, " fmt"},       64'(fmt), 64'(vecs[i].fmt));
      chk({t, " rd"},        64'(rd), 64'(vecs[i].rd));
      chk({t, " rs1"},       64'(rs1), 64'(vecs[i].rs1));
      chk({t, " rs2"},       64'(rs2), 64'(vecs[i].rs2));
      chk({t, " funct3"},    64'(funct3), 64'(vecs[i].f3));
      chk({t, " funct7"},    64'(funct7), 64'(vecs[i].f7));
      chk({t, " imm"},       64'(imm), 64'(vecs[i].imm));
      chk({t, " illegal"},   64'(illegal), 64'(ILL_EN & vecs[i].ill32));
      chk({t, " imm64"},     imm64, vecs[i].imm64);
      chk({t, " fmt64"},     64'(fmt64), 64'(vecs[i].fmt));
      chk({t, " illegal64"}, 64'(illegal64), 64'(ILL_EN & vecs[i].ill64));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_empty_fields({t, " popped"});
    end

    // Fill to DEPTH with the consumer stalled; the 5th is held off
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d in_ready", k), 64'(in_ready), 64'd1);
      push_one(32'h00000013 | (32'(k + 1) << 7), 32'h200 + 32'(4 * k));
    end
    chk("full in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_instr = 32'h00000013 | (32'd5 << 7); in_pc = 32'h210;
    tick();
    tick();
    chk("full held in_ready", 64'(in_ready), 64'd0);
    chk("full stable out_pc", 64'(out_pc), 64'h200);
    chk("full stable rd", 64'(rd), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("drain1 out_pc", 64'(out_pc), 64'h204);
    chk("drain1 in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("drain2 out_pc", 64'(out_pc), 64'h208);
    chk("drain2 in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("drain3 out_pc", 64'(out_pc), 64'h20C);
    tick();
    chk("drain4 out_pc", 64'(out_pc), 64'h210);
    chk("drain4 rd", 64'(rd), 64'd5);
    tick();
    out_ready = 1'b0;
    chk_empty_fields("drained");

    // Flush beats a same-cycle push and pop
    push_one(vecs[0].instr, 32'h300);
    push_one(vecs[2].instr, 32'h304);
    chk("preflush out_pc", 64'(out_pc), 64'h300);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = vecs[4].instr; in_pc = 32'h308;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty_fields("flush");
    chk("flush in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush lost push", 64'(out_valid), 64'd0);

    // Reset with three entries buffered and a push pending
    push_one(vecs[0].instr, 32'h400);
    push_one(vecs[1].instr, 32'h404);
    push_one(vecs[2].instr, 32'h408);
    chk("prereset out_pc", 64'(out_pc), 64'h400);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1; in_instr = vecs[4].instr; in_pc = 32'h40C;
    tick();
    chk("midreset in_ready", 64'(in_ready), 64'd0);
    chk_empty_fields("midreset");
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    chk("release in_ready", 64'(in_ready), 64'd1);
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release out_valid64", 64'(out_valid64), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
